mem_arbiter: RTL and testbench

- Sequences all accesses to the single-port synchronous main memory (12-bit words, 1-cycle read latency).
- Shares the memory between three requesters:
  - program loader (serial download path)
  - core instruction fetch
  - core data load/store
- Loader has strict priority. Fetch and data alternate round-robin.
- One transaction is in flight at a time. All state advances only on clock-enable steps, so the arbiter tracks the CPU clock-enable rate.

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between the program
// loader, core instruction fetch and core data port. The loader always wins.
// Fetch and data alternate when both request. One transaction is in flight at
// a time, and every register advances only on clock-enable steps.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int MEM_DEPTH  = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_gnt,
  output logic                  ld_ack,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_ack,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {OWN_LD, OWN_IF, OWN_DM} owner_t;

  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_DEPTH);

  state_t                state;
  state_t                state_nx;
  owner_t                owner;
  owner_t                sel_owner;
  logic                  last_dm;    // 1: data port won the last fetch/data contest
  logic                  cur_we;
  logic                  cur_ok;     // latched address was in range
  logic                  any_req;
  logic                  sel_we;
  logic                  sel_ok;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign any_req = ld_req | if_req | dm_req;
  assign sel_ok  = (sel_addr < DEPTH);

  // Pick the requester that would win an arbitration this step.
  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_owner = OWN_DM;
    sel_we    = dm_we;
    sel_addr  = dm_addr;
    sel_wdata = dm_wdata;
    if (ld_req) begin
      sel_owner = OWN_LD;
      sel_we    = ld_we;
      sel_addr  = ld_addr;
      sel_wdata = ld_wdata;
    end else if (if_req && (!dm_req || last_dm)) begin
      sel_owner = OWN_IF;
      sel_we    = 1'b0;
      sel_addr  = if_addr;
      sel_wdata = '0;
    end
  end

  // State register, advanced only on enabled steps.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_nx;
    end
  end

  // Next-state: writes finish in ACCESS, reads take one more step in RESP.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  state_nx = cur_we ? IDLE : RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered outputs and transaction context; gnt/ack/err are one-step pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_gnt    <= 1'b0;
      ld_ack    <= 1'b0;
      if_gnt    <= 1'b0;
      if_ack    <= 1'b0;
      dm_gnt    <= 1'b0;
      dm_ack    <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      owner     <= OWN_LD;
      last_dm   <= 1'b1;
      cur_we    <= 1'b0;
      cur_ok    <= 1'b0;
    end else if (ce) begin
      ld_gnt <= 1'b0;
      if_gnt <= 1'b0;
      dm_gnt <= 1'b0;
      ld_ack <= 1'b0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= sel_owner;
            cur_we    <= sel_we;
            cur_ok    <= sel_ok;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_we    <= sel_we && sel_ok;
            ld_gnt    <= (sel_owner == OWN_LD);
            if_gnt    <= (sel_owner == OWN_IF);
            dm_gnt    <= (sel_owner == OWN_DM);
            // Loader grants leave the fetch/data rotation untouched.
            if (sel_owner != OWN_LD) last_dm <= (sel_owner == OWN_DM);
          end else begin
            mem_we <= 1'b0;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (cur_we) begin
            ld_ack <= (owner == OWN_LD);
            if_ack <= (owner == OWN_IF);
            dm_ack <= (owner == OWN_DM);
            err    <= !cur_ok;
          end
        end
        RESP: begin
          rdata  <= cur_ok ? mem_rdata : '0;
          err    <= !cur_ok;
          ld_ack <= (owner == OWN_LD);
          if_ack <= (owner == OWN_IF);
          dm_ack <= (owner == OWN_DM);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions, hand
// sequences for contention, loader priority, reset abort and slow clock enable.
// Expected acks are queued when stimulus is driven and popped by a monitor.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        ce = 1'b1;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [11:0] ld_addr = '0, ld_wdata = '0;
  logic        if_req = 1'b0;
  logic [11:0] if_addr = '0;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [11:0] dm_addr = '0, dm_wdata = '0;
  logic        ld_gnt, ld_ack, if_gnt, if_ack, dm_gnt, dm_ack, err, mem_we;
  logic [11:0] rdata, mem_addr, mem_wdata;
  logic [11:0] mem_rdata = '0;

  mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .MEM_DEPTH(255)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_ack(ld_ack),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_ack(dm_ack),
    .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Clock enable: every cycle, or one cycle in four when slow_ce is set.
  bit slow_ce = 1'b0;
  int ph = 0;
  always @(negedge clk) begin
    ph = ph + 1;
    ce = slow_ce ? (ph % 4 == 0) : 1'b1;
  end

  bit stepped = 1'b0;
  always @(posedge clk) stepped <= ce;

  // Memory model: synchronous single port, one-step read latency, preloaded once.
  logic [11:0] mem [4096];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 12'h000;
      mem[12'h005] <= 12'hABC;
      mem[12'h030] <= 12'h3C3;
      mem[12'h040] <= 12'h404;
      mem[12'h041] <= 12'h414;
      mem[12'h0FF] <= 12'h777;
      mem[12'h100] <= 12'h888;
      loaded <= 1'b1;
    end else if (ce) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard entry; who is one-hot {ld, if, dm}.
  typedef struct {
    logic [2:0]  who;
    logic        we;
    logic [11:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb [$];

  // Monitor: on each step, checks ack against the scoreboard; between steps,
  // checks that nothing moved.
  logic [2:0]  m_ack, m_gnt;
  exp_t        m_e;
  logic [43:0] cur_out, prev_out;
  bit          prev_valid = 1'b0;
  always @(negedge clk) begin
    cur_out = {ld_gnt, if_gnt, dm_gnt, ld_ack, if_ack, dm_ack, err, rdata,
               mem_addr, mem_we, mem_wdata};
    if (reset_n) begin
      if (stepped) begin
        m_ack = {ld_ack, if_ack, dm_ack};
        m_gnt = {ld_gnt, if_gnt, dm_gnt};
        check("one_gnt", 32'($countones(m_gnt) <= 1), 1);
        check("one_ack", 32'($countones(m_ack) <= 1), 1);
        if (m_ack != 3'b000) begin
          if (sb.size() == 0) begin
            check("unexpected_ack", 32'(m_ack), 0);
          end else begin
            m_e = sb.pop_front();
            check("ack_owner", 32'(m_ack), 32'(m_e.who));
            check("err", 32'(err), 32'(m_e.err));
            if (!m_e.we) check("rdata", 32'(rdata), 32'(m_e.rdata));
          end
        end
      end else if (prev_valid) begin
        check("frozen", 32'(cur_out == prev_out), 1);
      end
    end
    prev_out   = cur_out;
    prev_valid = reset_n;
  end

  // One enabled step; returns shortly after the following falling edge.
  task automatic step();
    do @(posedge clk); while (!ce);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    sb.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 12) begin
      step();
      n++;
    end
    check("drain", 32'(sb.size()), 0);
    sb.delete();
  endtask

  typedef struct {
    logic [2:0]  who;
    logic        we;
    logic [11:0] addr;
    logic [11:0] wdata;
    logic [11:0] rdata;
    logic        err;
  } vec_t;

  // Single uncontested transaction from an idle arbiter.
  task automatic run_vec(input vec_t v);
    int n = 0;
    bit got = 1'b0;
    sb.push_back('{v.who, v.we, v.rdata, v.err});
    case (v.who)
      3'b100: begin ld_req = 1'b1; ld_we = v.we; ld_addr = v.addr; ld_wdata = v.wdata; end
      3'b010: begin if_req = 1'b1; if_addr = v.addr; end
      default: begin dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; end
    endcase
    while (!got && n < 10) begin
      step();
      n++;
      got = ({ld_gnt, if_gnt, dm_gnt} == v.who);
    end
    check("gnt_step", 32'(n), 1);
    if (got) begin
      check("mem_addr", 32'(mem_addr), 32'(v.addr));
      check("mem_we", 32'(mem_we), 32'(v.we && !v.err));
      if (v.we) check("mem_wdata", 32'(mem_wdata), 32'(v.wdata));
    end
    ld_req = 1'b0;
    if_req = 1'b0;
    dm_req = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      step();
      n++;
      if (n == 1) check("we_drop", 32'(mem_we), 0);
    end
    check("ack_latency", 32'(n), v.we ? 1 : 2);
    sb.delete();
  endtask

  // Contested requests already driven by the caller; checks the grant order.
  task automatic run_race(input logic [2:0] seq [8], input int len,
                          input int ld_cnt, input int gap);
    int k = 0, n = 0, last = 0, nld = 0;
    logic [2:0] g;
    while (k < len && n < 60) begin
      step();
      n++;
      g = {ld_gnt, if_gnt, dm_gnt};
      if (g != 3'b000) begin
        check("race_gnt", 32'(g), 32'(seq[k]));
        if (gap != 0 && k > 0) check("race_gap", 32'(n - last), 32'(gap));
        last = n;
        k++;
        if (g == 3'b100) begin
          nld++;
          if (nld == ld_cnt) ld_req = 1'b0;
        end
        if (k == len) begin
          ld_req = 1'b0;
          if_req = 1'b0;
          dm_req = 1'b0;
        end
      end
    end
    check("race_count", 32'(k), 32'(len));
    drain();
  endtask

  vec_t       vecs [12];
  logic [2:0] seq [8];
  int         n;

  initial begin
    vecs[0]  = '{3'b010, 1'b0, 12'h005, 12'h000, 12'hABC, 1'b0};
    vecs[1]  = '{3'b001, 1'b1, 12'h010, 12'h123, 12'h000, 1'b0};
    vecs[2]  = '{3'b001, 1'b0, 12'h010, 12'h000, 12'h123, 1'b0};
    vecs[3]  = '{3'b100, 1'b1, 12'h020, 12'h456, 12'h000, 1'b0};
    vecs[4]  = '{3'b100, 1'b0, 12'h020, 12'h000, 12'h456, 1'b0};
    vecs[5]  = '{3'b010, 1'b0, 12'h020, 12'h000, 12'h456, 1'b0};
    vecs[6]  = '{3'b001, 1'b1, 12'h0FF, 12'h321, 12'h000, 1'b1};
    vecs[7]  = '{3'b001, 1'b0, 12'h100, 12'h000, 12'h000, 1'b1};
    vecs[8]  = '{3'b001, 1'b0, 12'h0FF, 12'h000, 12'h000, 1'b1};
    vecs[9]  = '{3'b100, 1'b1, 12'h0FE, 12'h0EE, 12'h000, 1'b0};
    vecs[10] = '{3'b010, 1'b0, 12'h0FE, 12'h000, 12'h0EE, 1'b0};
    vecs[11] = '{3'b100, 1'b1, 12'hFFF, 12'h555, 12'h000, 1'b1};

    // Reset state.
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ctrl", 32'({ld_gnt, ld_ack, if_gnt, if_ack, dm_gnt, dm_ack, err, mem_we}), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    reset_n = 1'b1;

    // Single transactions: first fetch after reset, writes, reads, range edges.
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Fetch/data alternation from reset, one read grant every 3 steps.
    do_reset();
    seq = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    sb.push_back('{3'b010, 1'b0, 12'h404, 1'b0});
    sb.push_back('{3'b001, 1'b0, 12'h414, 1'b0});
    sb.push_back('{3'b010, 1'b0, 12'h404, 1'b0});
    sb.push_back('{3'b001, 1'b0, 12'h414, 1'b0});
    if_req = 1'b1; if_addr = 12'h040;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h041;
    run_race(seq, 4, 0, 3);

    // Loader priority over both; rotation resumes with fetch (data went last).
    seq = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000};
    for (int i = 0; i < 3; i++) sb.push_back('{3'b100, 1'b1, 12'h000, 1'b0});
    sb.push_back('{3'b010, 1'b0, 12'h404, 1'b0});
    sb.push_back('{3'b001, 1'b0, 12'h414, 1'b0});
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 12'h050; ld_wdata = 12'h5A5;
    if_req = 1'b1; if_addr = 12'h040;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h041;
    run_race(seq, 5, 3, 0);
    run_vec('{3'b001, 1'b0, 12'h050, 12'h000, 12'h5A5, 1'b0});

    // Reset in the middle of a write: immediate clear, no ack, write dropped.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 12'h030; dm_wdata = 12'h999;
    n = 0;
    while (!dm_gnt && n < 10) begin
      step();
      n++;
    end
    check("abort_gnt", 32'(dm_gnt), 1);
    check("abort_we_before", 32'(mem_we), 1);
    reset_n = 1'b0;
    dm_req = 1'b0;
    #1;
    check("abort_ctrl", 32'({ld_gnt, ld_ack, if_gnt, if_ack, dm_gnt, dm_ack, err, mem_we}), 0);
    check("abort_bus", 32'({mem_addr, mem_wdata}), 0);
    check("abort_rdata", 32'(rdata), 0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    sb.delete();
    repeat (4) step();
    run_vec('{3'b001, 1'b0, 12'h030, 12'h000, 12'h3C3, 1'b0});

    // Clock enable one in four: latencies counted in steps are unchanged.
    slow_ce = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    run_vec('{3'b001, 1'b1, 12'h070, 12'h1F1, 12'h000, 1'b0});
    run_vec('{3'b001, 1'b0, 12'h070, 12'h000, 12'h1F1, 1'b0});
    run_vec('{3'b010, 1'b0, 12'h005, 12'h000, 12'hABC, 1'b0});
    run_vec('{3'b100, 1'b1, 12'h100, 12'h222, 12'h000, 1'b1});
    slow_ce = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
